// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, fetch FSM states and opcode constants for the 16-bit pipeline
package cpu_pkg;

    localparam int XLEN = 16;

    typedef logic [XLEN-1:0] word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_HOLD,
        ST_DRAIN,
        ST_HALTED
    } fetch_state_t;

    localparam logic [3:0] OP_HALT = 4'b0000;
    localparam logic [3:0] OP_JMP  = 4'b0111;

    // Instruction addresses are halfword aligned; bit 0 is always forced low.
    function automatic word_t even_addr(input word_t a);
        return {a[XLEN-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// rtl/fetch_stage_if.sv - instruction memory req/ack bus between fetch stage and imem
interface fetch_stage_if;
    import cpu_pkg::*;

    logic  imem_req;
    word_t imem_addr;
    logic  imem_ack;
    word_t imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - single-entry {instr, pc} skid buffer for fetches completing under stall
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  logic  load,
    input  logic  unload,
    input  logic  clear,
    input  word_t load_instr,
    input  word_t load_pc,
    output word_t instr,
    output word_t pc,
    output logic  full
);

    // Capture on load; unload and clear both empty the entry.
    always_ff @(posedge clk) begin
        if (!reset) begin
            full  <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear || unload) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, imem req/ack fetch FSM, kill flag, skid and IF/ID register
module fetch_stage
    import cpu_pkg::*;
#(
    parameter word_t RESET_PC = 16'h0000,
    parameter int    PC_STEP  = 2
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic               stall_i,
    input  logic               pc_op,
    input  logic               b_jmp,
    input  logic               if_flush,
    input  logic               halt,
    input  word_t              branch_target,
    input  word_t              jump_target,
    fetch_stage_if.master      imem,
    output word_t              if_id_instr,
    output word_t              if_id_pc,
    output logic               if_id_valid,
    output logic               halted
);

    fetch_state_t state;
    word_t        pc;
    word_t        addr_q;
    logic         req_q;
    logic         kill;

    word_t        pc_inc;
    word_t        target;
    word_t        fetch_next;
    logic         ack;
    logic         redirect;
    logic         skid_load;
    logic         skid_unload;
    logic         skid_clear;
    word_t        skid_instr;
    word_t        skid_pc;
    logic         skid_full;

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;

    assign pc_inc     = pc + word_t'(PC_STEP);
    assign target     = even_addr(b_jmp ? branch_target : jump_target);
    // A killed response leaves pc already at the redirect target, so refetch pc itself.
    assign fetch_next = kill ? pc : pc_inc;
    // req_q is only ever high in FETCH or DRAIN, so a late ack elsewhere is ignored.
    assign ack        = req_q && imem.imem_ack;
    assign redirect   = pc_op && !stall_i;

    assign skid_load   = (state == ST_FETCH) && ack && stall_i && !halt && !kill && !if_flush;
    assign skid_unload = (state == ST_HOLD) && !stall_i && !halt;
    assign skid_clear  = redirect || halt;

    fetch_skid_buf u_skid (
        .clk        (clk),
        .reset      (reset),
        .load       (skid_load),
        .unload     (skid_unload),
        .clear      (skid_clear),
        .load_instr (imem.imem_rdata),
        .load_pc    (pc_inc),
        .instr      (skid_instr),
        .pc         (skid_pc),
        .full       (skid_full)
    );

    // Fetch FSM with registered request/address, PC, kill flag and IF/ID register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= ST_IDLE;
            pc          <= RESET_PC;
            addr_q      <= RESET_PC;
            req_q       <= 1'b0;
            kill        <= 1'b0;
            if_id_instr <= '0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (halt) begin
                        state  <= ST_HALTED;
                        halted <= 1'b1;
                    end else begin
                        state  <= ST_FETCH;
                        req_q  <= 1'b1;
                        addr_q <= pc;
                    end
                end
                ST_FETCH: begin
                    if (halt) begin
                        if_id_valid <= 1'b0;
                        kill        <= 1'b0;
                        if (ack) begin
                            state  <= ST_HALTED;
                            req_q  <= 1'b0;
                            halted <= 1'b1;
                        end else begin
                            state <= ST_DRAIN;
                        end
                    end else if (redirect) begin
                        pc          <= target;
                        if_id_valid <= 1'b0;
                        if (ack) begin
                            kill   <= 1'b0;
                            addr_q <= target;
                        end else begin
                            kill <= 1'b1;
                        end
                    end else if (ack) begin
                        if (!kill) begin
                            pc <= pc_inc;
                        end
                        kill   <= 1'b0;
                        addr_q <= fetch_next;
                        if (stall_i) begin
                            state <= ST_HOLD;
                            req_q <= 1'b0;
                            if (if_flush) begin
                                if_id_valid <= 1'b0;
                            end
                        end else if (kill || if_flush) begin
                            if_id_valid <= 1'b0;
                        end else begin
                            if_id_instr <= imem.imem_rdata;
                            if_id_pc    <= pc_inc;
                            if_id_valid <= 1'b1;
                        end
                    end else if (if_flush || !stall_i) begin
                        if_id_valid <= 1'b0;
                    end
                end
                ST_HOLD: begin
                    if (halt) begin
                        state       <= ST_HALTED;
                        halted      <= 1'b1;
                        if_id_valid <= 1'b0;
                    end else if (redirect) begin
                        state       <= ST_FETCH;
                        pc          <= target;
                        addr_q      <= target;
                        req_q       <= 1'b1;
                        if_id_valid <= 1'b0;
                    end else if (!stall_i) begin
                        state       <= ST_FETCH;
                        req_q       <= 1'b1;
                        addr_q      <= pc;
                        if_id_instr <= skid_instr;
                        if_id_pc    <= skid_pc;
                        if_id_valid <= skid_full && !if_flush;
                    end else if (if_flush) begin
                        if_id_valid <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (ack) begin
                        state  <= ST_HALTED;
                        req_q  <= 1'b0;
                        halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    req_q       <= 1'b0;
                    if_id_valid <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;
    import cpu_pkg::*;

    logic  clk = 1'b0;
    logic  reset;
    logic  stall_i;
    logic  pc_op;
    logic  b_jmp;
    logic  if_flush;
    logic  halt;
    word_t branch_target;
    word_t jump_target;
    word_t if_id_instr;
    word_t if_id_pc;
    logic  if_id_valid;
    logic  halted;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_stage_if bus ();

    // Instruction memory model: word at address a is a ^ 16'hA500.
    assign bus.imem_rdata = bus.imem_addr ^ 16'hA500;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall_i       (stall_i),
        .pc_op         (pc_op),
        .b_jmp         (b_jmp),
        .if_flush      (if_flush),
        .halt          (halt),
        .branch_target (branch_target),
        .jump_target   (jump_target),
        .imem          (bus),
        .if_id_instr   (if_id_instr),
        .if_id_pc      (if_id_pc),
        .if_id_valid   (if_id_valid),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; stall_i = 1'b0; pc_op = 1'b0; b_jmp = 1'b0; if_flush = 1'b0; halt = 1'b0;
        branch_target = '0; jump_target = '0; bus.imem_ack = 1'b0;
        step(); step();
        chk("rst_req",    16'(bus.imem_req), 16'h0);
        chk("rst_addr",   bus.imem_addr,     16'h0000);
        chk("rst_instr",  if_id_instr,       16'h0000);
        chk("rst_pc",     if_id_pc,          16'h0000);
        chk("rst_valid",  16'(if_id_valid),  16'h0);
        chk("rst_halted", 16'(halted),       16'h0);

        // Sequential fetch with ack every cycle
        reset = 1'b1; bus.imem_ack = 1'b1;
        step();
        chk("seq1_req",   16'(bus.imem_req), 16'h1);
        chk("seq1_addr",  bus.imem_addr,     16'h0000);
        chk("seq1_valid", 16'(if_id_valid),  16'h0);
        step();
        chk("seq2_valid", 16'(if_id_valid),  16'h1);
        chk("seq2_instr", if_id_instr,       16'hA500);
        chk("seq2_pc",    if_id_pc,          16'h0002);
        chk("seq2_addr",  bus.imem_addr,     16'h0002);
        step();
        chk("seq3_instr", if_id_instr,       16'hA502);
        chk("seq3_pc",    if_id_pc,          16'h0004);
        chk("seq3_addr",  bus.imem_addr,     16'h0004);

        // Stall while the ack for 0004 arrives
        stall_i = 1'b1;
        step();
        chk("stall_req",   16'(bus.imem_req), 16'h0);
        chk("stall_instr", if_id_instr,       16'hA502);
        chk("stall_valid", 16'(if_id_valid),  16'h1);
        step();
        chk("stall2_req",   16'(bus.imem_req), 16'h0);
        chk("stall2_instr", if_id_instr,       16'hA502);
        stall_i = 1'b0;
        step();
        chk("unstall_instr", if_id_instr,       16'hA504);
        chk("unstall_pc",    if_id_pc,          16'h0006);
        chk("unstall_valid", 16'(if_id_valid),  16'h1);
        chk("unstall_req",   16'(bus.imem_req), 16'h1);
        chk("unstall_addr",  bus.imem_addr,     16'h0006);
        step();
        chk("seq4_instr", if_id_instr,   16'hA506);
        chk("seq4_addr",  bus.imem_addr, 16'h0008);

        // Redirect with kill while 0008 is outstanding
        bus.imem_ack = 1'b0; pc_op = 1'b1; b_jmp = 1'b1; branch_target = 16'h0041; if_flush = 1'b1;
        step();
        chk("redir_valid", 16'(if_id_valid),  16'h0);
        chk("redir_addr",  bus.imem_addr,     16'h0008);
        chk("redir_req",   16'(bus.imem_req), 16'h1);
        pc_op = 1'b0; if_flush = 1'b0; bus.imem_ack = 1'b1;
        step();
        chk("kill_valid", 16'(if_id_valid), 16'h0);
        chk("kill_addr",  bus.imem_addr,    16'h0040);
        step();
        chk("tgt_instr", if_id_instr,      16'hA540);
        chk("tgt_pc",    if_id_pc,         16'h0042);
        chk("tgt_valid", 16'(if_id_valid), 16'h1);
        chk("tgt_addr",  bus.imem_addr,    16'h0042);

        // Halt with a request outstanding, ack delayed three cycles
        bus.imem_ack = 1'b0; halt = 1'b1;
        step();
        chk("drain1_req",    16'(bus.imem_req), 16'h1);
        chk("drain1_halted", 16'(halted),       16'h0);
        chk("drain1_valid",  16'(if_id_valid),  16'h0);
        step(); step();
        chk("drain3_req",  16'(bus.imem_req), 16'h1);
        chk("drain3_addr", bus.imem_addr,     16'h0042);
        bus.imem_ack = 1'b1;
        step();
        chk("halt_req",    16'(bus.imem_req), 16'h0);
        chk("halt_halted", 16'(halted),       16'h1);
        chk("halt_valid",  16'(if_id_valid),  16'h0);
        halt = 1'b0;
        step(); step();
        chk("halt_stay_req",    16'(bus.imem_req), 16'h0);
        chk("halt_stay_halted", 16'(halted),       16'h1);

        // Wrap: jump to odd FFFF, forced to FFFE, then fetch there
        reset = 1'b0; step();
        chk("rst2_halted", 16'(halted), 16'h0);
        reset = 1'b1; bus.imem_ack = 1'b0;
        step();
        pc_op = 1'b1; b_jmp = 1'b0; jump_target = 16'hFFFF;
        step();
        chk("wrap_kill_addr", bus.imem_addr, 16'h0000);
        pc_op = 1'b0; bus.imem_ack = 1'b1;
        step();
        chk("wrap_tgt_addr", bus.imem_addr, 16'hFFFE);
        step();
        chk("wrap_instr", if_id_instr,      16'h5AFE);
        chk("wrap_pc",    if_id_pc,         16'h0000);
        chk("wrap_valid", 16'(if_id_valid), 16'h1);
        chk("wrap_addr",  bus.imem_addr,    16'h0000);

        // Reset mid-request
        reset = 1'b0;
        step();
        chk("midrst_req",   16'(bus.imem_req), 16'h0);
        chk("midrst_addr",  bus.imem_addr,     16'h0000);
        chk("midrst_instr", if_id_instr,       16'h0000);
        chk("midrst_pc",    if_id_pc,          16'h0000);
        chk("midrst_valid", 16'(if_id_valid),  16'h0);
        reset = 1'b1;
        step();
        chk("late_ack_valid", 16'(if_id_valid),  16'h0);
        chk("late_ack_req",   16'(bus.imem_req), 16'h1);
        chk("late_ack_addr",  bus.imem_addr,     16'h0000);

        // Flush on an arriving ack drops the data but still advances pc
        if_flush = 1'b1;
        step();
        chk("flush_valid", 16'(if_id_valid), 16'h0);
        chk("flush_addr",  bus.imem_addr,    16'h0002);
        if_flush = 1'b0;
        step();
        chk("postflush_instr", if_id_instr,      16'hA502);
        chk("postflush_pc",    if_id_pc,         16'h0004);
        chk("postflush_valid", 16'(if_id_valid), 16'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
